// File: rtl/enc_poll_ctrl_if.sv
// Encoder-side bus between enc_poll_ctrl and a bank of rotary_enc instances.
//   enc_read_enable : per-channel read_enable handshake, driven by the scanner
//   enc_move        : packed signed 8-bit step counts, channel i at [8i+7:8i]
// master modport = scan controller, slave modport = encoder bank.
interface enc_poll_ctrl_if #(
  parameter int N_ENC = 4
);
  logic [N_ENC-1:0]   enc_read_enable;
  logic [8*N_ENC-1:0] enc_move;

  modport master (output enc_read_enable, input enc_move);
  modport slave  (input enc_read_enable, output enc_move);
endinterface

// File: rtl/enc_poll_ctrl.sv
// Scan controller for a bank of rotary encoders. One sequencer walks every
// channel once per poll period, holds read_enable, samples the signed step
// count and folds it into a clamped per-channel value with a sticky change flag.
// Ports:
//   aclk, reset   : clock, synchronous active-high reset
//   enc           : encoder bus (read_enable out, move in)
//   value         : packed per-channel values, channel i at [VAL_W*i +: VAL_W]
//   changed       : sticky change flags, cleared by clr_changed pulses
//   load_en/idx/val : preload strobe, channel and value (clamped)
//   busy          : high while a scan is in progress
//
// state     | meaning
// S_IDLE    | poll timer running, waiting for next scan start
// S_ASSERT  | read_enable[idx] high, hold counter running
// S_SAMPLE  | read_enable[idx] still high, move captured into value[idx]
// S_RELEASE | read_enable low one cycle, advance to next channel or idle
module enc_poll_ctrl #(
  parameter int N_ENC       = 4,
  parameter int POLL_CYCLES = 100000,
  parameter int HOLD_CYCLES = 4,
  parameter int VAL_W       = 16,
  parameter int VAL_MIN     = 0,
  parameter int VAL_MAX     = 1023
) (
  input  logic                   aclk,
  input  logic                   reset,
  enc_poll_ctrl_if.master        enc,
  output logic [VAL_W*N_ENC-1:0] value,
  output logic [N_ENC-1:0]       changed,
  input  logic [N_ENC-1:0]       clr_changed,
  input  logic                   load_en,
  input  logic [2:0]             load_idx,
  input  logic [VAL_W-1:0]       load_val,
  output logic                   busy
);
  localparam int TW = $clog2(POLL_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int IW = (N_ENC > 1) ? $clog2(N_ENC) : 1;
  localparam logic [TW-1:0] TMR_LAST  = TW'(POLL_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_ENC - 1);
  localparam logic [VAL_W-1:0] MIN_U  = VAL_W'(VAL_MIN);
  localparam logic [VAL_W-1:0] MAX_U  = VAL_W'(VAL_MAX);
  localparam logic signed [VAL_W+1:0] MIN_S = (VAL_W+2)'(VAL_MIN);
  localparam logic signed [VAL_W+1:0] MAX_S = (VAL_W+2)'(VAL_MAX);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SAMPLE, S_RELEASE} state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [VAL_W-1:0]    val_q [N_ENC];
  logic [VAL_W-1:0]    val_d [N_ENC];
  logic [N_ENC-1:0]    chg_q, chg_d;
  logic [N_ENC-1:0]    idx_hot, en;
  logic [7:0]          move_sel;
  logic [VAL_W-1:0]    val_sel;
  logic signed [VAL_W+1:0] sum;
  logic [VAL_W-1:0]    step_res, load_res;

  // Two spare bits keep zext(value)+sext(move) from overflowing before the clamp.
  function automatic logic [VAL_W-1:0] clamp_s(input logic signed [VAL_W+1:0] x);
    if (x < MIN_S) return MIN_U;
    if (x > MAX_S) return MAX_U;
    return x[VAL_W-1:0];
  endfunction

  always_comb begin
    idx_hot  = '0;
    move_sel = '0;
    val_sel  = '0;
    for (int i = 0; i < N_ENC; i++) begin
      if (idx_q == IW'(i)) begin
        idx_hot[i] = 1'b1;
        move_sel   = enc.enc_move[8*i +: 8];
        val_sel    = val_q[i];
      end
    end
  end

  assign sum      = $signed({2'b00, val_sel}) + $signed({{(VAL_W-6){move_sel[7]}}, move_sel});
  assign step_res = clamp_s(sum);
  assign load_res = clamp_s($signed({2'b00, load_val}));

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    hold_d  = '0;
    idx_d   = idx_q;
    en      = '0;
    unique case (state_q)
      S_IDLE: begin
        if (timer_q == TMR_LAST) begin
          state_d = S_ASSERT;
          timer_d = '0;
        end
      end
      S_ASSERT: begin
        en = idx_hot;
        if (hold_q == HOLD_LAST) state_d = S_SAMPLE;
        else                     hold_d  = hold_q + 1'b1;
      end
      S_SAMPLE: begin
        en      = idx_hot;
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_ASSERT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Preload is applied after the sample update so it wins on a shared channel;
  // sets are OR-ed after the clear so a same-cycle set survives clr_changed.
  always_comb begin
    val_d = val_q;
    chg_d = chg_q & ~clr_changed;
    for (int i = 0; i < N_ENC; i++) begin
      if (state_q == S_SAMPLE && idx_hot[i]) begin
        val_d[i] = step_res;
        if (step_res != val_q[i]) chg_d[i] = 1'b1;
      end
      if (load_en && load_idx == 3'(i)) begin
        val_d[i] = load_res;
        chg_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      hold_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      chg_q <= '0;
      for (int i = 0; i < N_ENC; i++) val_q[i] <= MIN_U;
    end else begin
      chg_q <= chg_d;
      for (int i = 0; i < N_ENC; i++) val_q[i] <= val_d[i];
    end
  end

  assign enc.enc_read_enable = en;
  assign changed = chg_q;
  assign busy    = (state_q != S_IDLE);

  for (genvar g = 0; g < N_ENC; g++) begin : g_val
    assign value[g*VAL_W +: VAL_W] = val_q[g];
  end
endmodule
